// File: rtl/image_pkg.sv
// Shared types and AXI encodings for the image burst sink.
package image_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } burst_state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_128    = 3'b100;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/image_stream_reg.sv
// Single-entry valid/ready output register feeding the image FIFO.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/data/last    beat offered by the write channel
//   in_ready_c            combinational accept (empty or draining this cycle)
//   out_valid/data/last   registered stream beat, held until out_ready
//   out_ready             downstream ready
module image_stream_reg #(
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready_c,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    // Accept when empty or when the held beat leaves on this edge.
    assign in_ready_c = ~out_valid | out_ready;

    // Load on accept; otherwise hold until the consumer takes the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (in_valid && in_ready_c) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/image_burst_sink.sv
// AXI4 write-burst slave forwarding 128-bit pixel beats into the image FIFO
// and raising a level interrupt that requests the next burst.
// Ports:
//   s_axi_aclk, s_axi_aresetn   clock, async active-low reset
//   s_axi_aw*                   write address (address decoded upstream)
//   s_axi_w*                    write data (strobes ignored)
//   s_axi_b*                    write response
//   m_t*                        stream to the image FIFO
//   fifo_free                   free words reported by the FIFO
//   irq_ack                     pulse from the request-length register read
//   irq_signal, req_len         burst request and its length in beats
module image_burst_sink
    import image_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ID_WIDTH   = 17,
    parameter int unsigned FREE_WIDTH = 13,
    parameter int unsigned MIN_REQ    = 16
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    input  logic                    m_tready,
    input  logic [FREE_WIDTH-1:0]   fifo_free,
    input  logic                    irq_ack,
    output logic                    irq_signal,
    output logic [8:0]              req_len
);

    localparam int unsigned LEN_WIDTH = 9;
    localparam int unsigned MAX_REQ   = 256;

    burst_state_t         state_q, state_d;
    logic [7:0]           awlen_q, awlen_d;
    logic [7:0]           beat_q, beat_d;
    logic [ID_WIDTH-1:0]  bid_d;
    logic                 err_q, err_d;
    logic                 irq_d;
    logic [LEN_WIDTH-1:0] req_len_d;

    logic aw_hs_c;
    logic w_hs_c;
    logic last_beat_c;
    logic stream_valid_c;
    logic stream_ready_c;
    logic wready_c;
    logic req_set_c;
    logic unused_ok;

    // Byte strobes carry no meaning for the pixel stream.
    assign unused_ok = ^s_axi_wstrb;

    assign s_axi_wready = wready_c;

    image_stream_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_stream_reg (
        .clk        (s_axi_aclk),
        .rst_n      (s_axi_aresetn),
        .in_valid   (stream_valid_c),
        .in_data    (s_axi_wdata),
        .in_last    (last_beat_c),
        .in_ready_c (stream_ready_c),
        .out_valid  (m_tvalid),
        .out_data   (m_tdata),
        .out_last   (m_tlast),
        .out_ready  (m_tready)
    );

    // Burst FSM next-state and request logic.
    always_comb begin
        state_d        = state_q;
        awlen_d        = awlen_q;
        beat_d         = beat_q;
        bid_d          = s_axi_bid;
        err_d          = err_q;
        irq_d          = irq_signal;
        req_len_d      = req_len;
        wready_c       = 1'b0;
        stream_valid_c = 1'b0;

        aw_hs_c     = s_axi_awready & s_axi_awvalid;
        last_beat_c = (beat_q == awlen_q);

        unique case (state_q)
            DATA: begin
                wready_c       = stream_ready_c;
                stream_valid_c = s_axi_wvalid;
            end
            DRAIN:   wready_c = 1'b1;
            default: wready_c = 1'b0;
        endcase

        w_hs_c = s_axi_wvalid & wready_c;

        unique case (state_q)
            IDLE: begin
                if (aw_hs_c) begin
                    awlen_d = s_axi_awlen;
                    bid_d   = s_axi_awid;
                    beat_d  = 8'd0;
                    if (s_axi_awburst == AXI_BURST_INCR && s_axi_awsize == AXI_SIZE_128) begin
                        state_d = DATA;
                    end else begin
                        state_d = DRAIN;
                        err_d   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_hs_c) begin
                    if (!last_beat_c) begin
                        beat_d = beat_q + 8'd1;
                    end
                    // Host framing disagrees with awlen: flag it, keep going.
                    if (s_axi_wlast != last_beat_c) begin
                        err_d = 1'b1;
                    end
                    if (s_axi_wlast || last_beat_c) begin
                        state_d = RESP;
                    end
                end
            end
            DRAIN: begin
                if (w_hs_c && s_axi_wlast) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (s_axi_bvalid && s_axi_bready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Request only once the previous burst has fully left the stream register.
        req_set_c = (state_q == IDLE) && !m_tvalid && !irq_signal && !aw_hs_c &&
                    (fifo_free >= FREE_WIDTH'(MIN_REQ));

        if (irq_ack || aw_hs_c) begin
            irq_d = 1'b0;
        end else if (req_set_c) begin
            irq_d = 1'b1;
            if (fifo_free > FREE_WIDTH'(MAX_REQ)) begin
                req_len_d = LEN_WIDTH'(MAX_REQ);
            end else begin
                req_len_d = LEN_WIDTH'(fifo_free);
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q       <= IDLE;
            awlen_q       <= 8'd0;
            beat_q        <= 8'd0;
            err_q         <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= AXI_RESP_OKAY;
            s_axi_bid     <= '0;
            irq_signal    <= 1'b0;
            req_len       <= '0;
        end else begin
            state_q       <= state_d;
            awlen_q       <= awlen_d;
            beat_q        <= beat_d;
            err_q         <= err_d;
            s_axi_awready <= (state_d == IDLE);
            s_axi_bvalid  <= (state_d == RESP);
            s_axi_bresp   <= (state_d == RESP && err_d) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            s_axi_bid     <= bid_d;
            irq_signal    <= irq_d;
            req_len       <= req_len_d;
        end
    end

endmodule

// File: tb/tb_image_burst_sink.sv
// Scoreboard bench for image_burst_sink: directed bursts, stream and B
// monitors popping expectation queues, plus directed interrupt checks.
module tb_image_burst_sink;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } beat_t;

    typedef struct {
        logic [16:0] id;
        logic [1:0]  resp;
    } bresp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [16:0]  awid;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [16:0]  bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;
    logic [12:0]  fifo_free;
    logic         irq_ack;
    logic         irq_signal;
    logic [8:0]   req_len;

    int checks = 0;
    int errors = 0;
    bit toggle_en = 1'b0;

    beat_t  exp_beats[$];
    bresp_t exp_b[$];

    image_burst_sink dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi_awid    (awid),
        .s_axi_awlen   (awlen),
        .s_axi_awsize  (awsize),
        .s_axi_awburst (awburst),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wlast   (wlast),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bid     (bid),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tlast       (m_tlast),
        .m_tready      (m_tready),
        .fifo_free     (fifo_free),
        .irq_ack       (irq_ack),
        .irq_signal    (irq_signal),
        .req_len       (req_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_beat(input logic [127:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        exp_beats.push_back(b);
    endtask

    task automatic push_b(input logic [16:0] id, input logic [1:0] resp);
        bresp_t b;
        b.id   = id;
        b.resp = resp;
        exp_b.push_back(b);
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic send_aw(input logic [16:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        awid    = id;
        awlen   = len;
        awburst = burst;
        awsize  = size;
        awvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!awready && n < 50);
        chk("aw_accept", 128'(awready), 128'(1));
        @(posedge clk);
        #1;
        awvalid = 1'b0;
    endtask

    // Sends nbeats beats base, base+1, ...; wlast only on index last_idx.
    task automatic send_w(input int nbeats, input logic [127:0] base, input int last_idx);
        int n;
        for (int i = 0; i < nbeats; i++) begin
            wdata  = base + 128'(i);
            wlast  = (i == last_idx);
            wvalid = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!wready && n < 50);
            chk("w_accept", 128'(wready), 128'(1));
            @(posedge clk);
            #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    // Waits until every expected beat and response has been seen.
    task automatic wait_done();
        int n = 0;
        while ((exp_beats.size() != 0 || exp_b.size() != 0) && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("scoreboard_drained", 128'(exp_beats.size() + exp_b.size()), 128'(0));
        exp_beats.delete();
        exp_b.delete();
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Stream monitor: compares beats as they are taken, and held data during stalls.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && m_tvalid) begin
                if (exp_beats.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0h last %0b expected none at %0t",
                             m_tdata, m_tlast, $time);
                end else if (m_tready) begin
                    e = exp_beats.pop_front();
                    chk("stream_data", m_tdata, e.data);
                    chk("stream_last", 128'(m_tlast), 128'(e.last));
                end else begin
                    chk("stall_hold_data", m_tdata, exp_beats[0].data);
                end
            end
        end
    end

    // Write-response monitor.
    initial begin
        bresp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bresp: got id %0h resp %0h expected none at %0t",
                             bid, bresp, $time);
                end else begin
                    e = exp_b.pop_front();
                    chk("bid", 128'(bid), 128'(e.id));
                    chk("bresp", 128'(bresp), 128'(e.resp));
                end
            end
        end
    end

    // Toggles m_tready every cycle when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) m_tready = ~m_tready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        awid      = '0;
        awlen     = '0;
        awsize    = '0;
        awburst   = '0;
        awvalid   = 1'b0;
        wdata     = '0;
        wstrb     = '1;
        wlast     = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b1;
        m_tready  = 1'b1;
        fifo_free = 13'd4000;
        irq_ack   = 1'b0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awready", 128'(awready), 128'(0));
        chk("rst_wready", 128'(wready), 128'(0));
        chk("rst_bvalid", 128'(bvalid), 128'(0));
        chk("rst_bresp", 128'(bresp), 128'(0));
        chk("rst_bid", 128'(bid), 128'(0));
        chk("rst_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_tlast", 128'(m_tlast), 128'(0));
        chk("rst_tdata", m_tdata, 128'(0));
        chk("rst_irq", 128'(irq_signal), 128'(0));
        chk("rst_req_len", 128'(req_len), 128'(0));

        // Release: request rises after one cycle with a capped length.
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_awready", 128'(awready), 128'(1));
        chk("post_rst_irq", 128'(irq_signal), 128'(1));
        chk("post_rst_req_len", 128'(req_len), 128'(256));
        irq_ack = 1'b1;
        cycle();
        irq_ack = 1'b0;
        chk("ack_clears_irq", 128'(irq_signal), 128'(0));
        cycle();

        // INCR burst of 4 at full throughput.
        for (int i = 1; i <= 4; i++) push_beat(128'(i), i == 4);
        push_b(17'h1_2345, 2'b00);
        send_aw(17'h1_2345, 8'd3, 2'b01, 3'b100);
        chk("aw_clears_irq", 128'(irq_signal), 128'(0));
        send_w(4, 128'd1, 3);
        wait_done();
        repeat (2) cycle();
        chk("irq_after_burst", 128'(irq_signal), 128'(1));
        chk("req_len_after_burst", 128'(req_len), 128'(256));

        // Same burst with back-pressure toggling.
        @(negedge clk);
        toggle_en = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) push_beat(128'h11 + 128'(i), i == 3);
        push_b(17'h0_0A5A, 2'b00);
        send_aw(17'h0_0A5A, 8'd3, 2'b01, 3'b100);
        send_w(4, 128'h11, 3);
        wait_done();
        @(negedge clk);
        toggle_en = 1'b0;
        m_tready  = 1'b1;
        cycle();

        // Early wlast: two beats, neither marked last, slave error.
        push_beat(128'hA1, 1'b0);
        push_beat(128'hA2, 1'b0);
        push_b(17'h0_0077, 2'b10);
        send_aw(17'h0_0077, 8'd3, 2'b01, 3'b100);
        send_w(2, 128'hA1, 1);
        wait_done();

        // Following good burst streams normally.
        push_beat(128'hB1, 1'b0);
        push_beat(128'hB2, 1'b1);
        push_b(17'h1_0001, 2'b00);
        send_aw(17'h1_0001, 8'd1, 2'b01, 3'b100);
        send_w(2, 128'hB1, 1);
        wait_done();

        // Missing wlast: burst ends on awlen, stream last set, slave error.
        push_beat(128'hC1, 1'b0);
        push_beat(128'hC2, 1'b1);
        push_b(17'h0_0100, 2'b10);
        send_aw(17'h0_0100, 8'd1, 2'b01, 3'b100);
        send_w(2, 128'hC1, -1);
        wait_done();

        // FIXED burst: beats drained, nothing streamed.
        push_b(17'h0_0ABC, 2'b10);
        send_aw(17'h0_0ABC, 8'd1, 2'b00, 3'b100);
        send_w(2, 128'hD1, 1);
        wait_done();
        repeat (3) cycle();

        // Below threshold: no request.
        fifo_free = 13'd10;
        irq_ack   = 1'b1;
        cycle();
        irq_ack = 1'b0;
        repeat (3) cycle();
        chk("no_irq_below_min", 128'(irq_signal), 128'(0));

        // Above threshold: request with exact length.
        fifo_free = 13'd100;
        cycle();
        chk("irq_at_100", 128'(irq_signal), 128'(1));
        chk("req_len_100", 128'(req_len), 128'(100));

        // Ack then re-arm: low for one cycle, high again.
        irq_ack = 1'b1;
        cycle();
        irq_ack = 1'b0;
        chk("rearm_low", 128'(irq_signal), 128'(0));
        cycle();
        chk("rearm_high", 128'(irq_signal), 128'(1));
        chk("rearm_req_len", 128'(req_len), 128'(100));

        // Length frozen while raised.
        fifo_free = 13'd300;
        cycle();
        chk("req_len_frozen", 128'(req_len), 128'(100));

        // Ack coinciding with the set condition: clear wins.
        irq_ack = 1'b1;
        cycle();
        chk("held_ack_1", 128'(irq_signal), 128'(0));
        cycle();
        irq_ack = 1'b0;
        chk("ack_beats_set", 128'(irq_signal), 128'(0));
        cycle();
        chk("rearm_after_ack", 128'(irq_signal), 128'(1));
        chk("rearm_req_len_cap", 128'(req_len), 128'(256));

        repeat (2) cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_burst_sink.md
# image_burst_sink

AXI4 write-burst slave that receives pixel data bursts from the PS at the ImageController data window and forwards them as a 128-bit stream into the image FIFO. It also raises a level interrupt requesting the next burst, sized from the FIFO's reported free space, which closes the IRQ → read length → write burst loop. It sits between the AXI interconnect (S00_AXI data window) and the image FIFO / HDMI pixel path, in the `s_axi_aclk` domain.

## Interface
- `DATA_WIDTH`, 128: W / stream data width.
- `ID_WIDTH`, 17: AXI ID width.
- `FREE_WIDTH`, 13: width of FIFO free-word count.
- `MIN_REQ`, 16: minimum free words before a request is raised.
- `s_axi_aclk`  in  1  clock.
- `s_axi_aresetn`  in  1  asynchronous active-low reset.
- `s_axi_awid`  in  ID_WIDTH; `s_axi_awlen` in 8; `s_axi_awsize` in 3; `s_axi_awburst` in 2; `s_axi_awvalid` in 1; `s_axi_awready` out 1: AW channel. Address is decoded upstream and ignored here.
- `s_axi_wdata`  in  DATA_WIDTH; `s_axi_wstrb` in DATA_WIDTH/8 (ignored); `s_axi_wlast` in 1; `s_axi_wvalid` in 1; `s_axi_wready` out 1: W channel.
- `s_axi_bid`  out  ID_WIDTH; `s_axi_bresp` out 2; `s_axi_bvalid` out 1; `s_axi_bready` in 1: B channel.
- `m_tdata`  out  DATA_WIDTH; `m_tvalid` out 1; `m_tlast` out 1; `m_tready` in 1: stream to image FIFO.
- `fifo_free`  in  FREE_WIDTH: free words in the image FIFO, registered by the FIFO.
- `irq_ack`  in  1: one-cycle pulse from the register read of the request length.
- `irq_signal`  out  1: level interrupt, meaning a burst is requested.
- `req_len`  out  9: requested beats (1..256), valid while `irq_signal`=1.

## Operation
- FSM states: IDLE, DATA, DRAIN, RESP.
- IDLE: `awready`=1. On AW handshake, latch `awid` and `awlen`, clear the beat counter, and clear `irq_signal`.
  - Go to DATA if `awburst`=INCR(01) and `awsize`=3'b100.
  - Otherwise go to DRAIN with the error flag set.
- DATA: `wready` = ~`m_tvalid` | `m_tready`. Each W handshake loads the output register and increments the beat counter (8-bit, no wrap beyond `awlen`).
  - `m_tlast` = (beat == latched `awlen`).
  - If `wlast` ≠ (beat == `awlen`), set the error flag and continue.
  - Leave on the handshake whose `wlast`=1, or when beat == `awlen`, whichever is first. Go to RESP.
- DRAIN: `wready`=1. Beats are discarded and never reach the stream. Leave on `wlast` and go to RESP.
- RESP: `bvalid`=1, `bid`=latched id, `bresp`=2'b10 if error else 2'b00. On `bready`, clear the error flag and go to IDLE.
- Request logic, evaluated every cycle:
  - When state=IDLE, `m_tvalid`=0, `irq_signal`=0, no AW handshake this cycle, and `fifo_free` ≥ MIN_REQ: set `irq_signal`=1 and `req_len` = min(`fifo_free`, 256).
  - `req_len` is frozen while `irq_signal`=1.
  - `irq_ack` clears `irq_signal`. If it coincides with the set condition, the clear wins, and the re-arm is evaluated next cycle.
- A host issuing `awlen`+1 > `req_len` is not checked here. The FIFO's overflow protection covers that case.

## Timing
- Reset values:
  - `awready`=0 during reset, 1 in the first cycle after reset.
  - `wready`=0, `bvalid`=0, `bresp`=0, `bid`=0.
  - `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0.
  - `irq_signal`=0, `req_len`=0.
  - State=IDLE.
- Stream latency: W handshake → `m_tvalid` on the next edge. Full throughput is 1 beat/cycle while `m_tready`=1.
- `m_tvalid`/`m_tdata`/`m_tlast` hold stable until `m_tready`.
- AW→first `wready`: 1 cycle. Last W handshake → `bvalid`: 1 cycle. `bvalid`→IDLE: same edge as `bready`.
- The next AW is accepted in the cycle after the B handshake.
- Reset asserted mid-burst: all state is dropped, and the partial stream is left without `m_tlast`. The FIFO is reset by the same reset.
- `irq_signal` rises ≥1 cycle after the final stream beat drains.

## Structure
- Package `image_pkg`:
  - typedef `burst_state_t` {IDLE, DATA, DRAIN, RESP}.
  - constants `AXI_BURST_INCR`=2'b01, `AXI_SIZE_128`=3'b100, `AXI_RESP_OKAY`=2'b00, `AXI_RESP_SLVERR`=2'b10.
- One sub-module, `image_stream_reg`: the single-entry valid/ready output register (`wready` generation plus data/last hold).

## Test plan
- Reset release, `fifo_free`=4000 → `irq_signal`=1 after one cycle, `req_len`=256. `irq_ack` pulse → `irq_signal`=0 next cycle.
- `awlen`=3, data 1..4 with `m_tready`=1 → 4 stream beats 1..4 on consecutive cycles, `m_tlast` on beat 4, `bresp`=OKAY, `bid` echoes `awid`.
- Same burst with `m_tready` toggling 1/0 each cycle → no beat lost or duplicated, data held during stalls, 4 beats total.
- `awlen`=3 with `wlast` on beat 2 → 2 stream beats, second with `m_tlast`=0, `bresp`=SLVERR. The next OKAY burst streams correctly.
- `awburst`=FIXED, `awlen`=1 → 0 stream beats, both W beats accepted, `bresp`=SLVERR.
- `fifo_free`=10 then 100 with MIN_REQ=16 → no IRQ at 10. IRQ with `req_len`=100 at 100. `irq_ack` and re-arm in the same cycle → IRQ low one cycle, then high again.
